// File: rtl/multicycle_datapath.sv
// Multicycle RV32 datapath: PC/OldPC/IR/Data/A/B/ALUOut, 32x32 regfile, ALU.
// Ports: clk_i, rst_i (sync, active-high); control inputs from the
// controller FSM; status op_o/funct3_o/funct7_o/zero_o; memory port
// mem_addr_o/mem_wdata_o/mem_we_o/mem_rdata_i. Optional macro
// MCDP_DBG_PORT_EN adds dbg_raddr_i/dbg_rdata_o regfile read port.
module multicycle_datapath (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef MCDP_DBG_PORT_EN
  input  logic [4:0]  dbg_raddr_i,
  output logic [31:0] dbg_rdata_o,
`endif
  input  logic        pc_write_i,
  input  logic        addr_src_i,
  input  logic        mem_write_i,
  input  logic        ir_write_i,
  input  logic [1:0]  result_src_i,
  input  logic [2:0]  alu_control_i,
  input  logic [1:0]  alu_src_a_i,
  input  logic [1:0]  alu_src_b_i,
  input  logic [2:0]  imm_src_i,
  input  logic        reg_write_i,
  output logic [6:0]  op_o,
  output logic [2:0]  funct3_o,
  output logic        funct7_o,
  output logic        zero_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  input  logic [31:0] mem_rdata_i
);

  logic [31:0] pc_q;
  logic [31:0] old_pc_q;
  logic [31:0] ir_q;
  logic [31:0] data_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] alu_out_q;
  logic [31:0] rf_q [32];

  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] imm_ext;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic [31:0] result;

  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign rd  = ir_q[11:7];

  // x0 is masked on read so its storage never matters.
  assign rd1 = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rd2 = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

`ifdef MCDP_DBG_PORT_EN
  assign dbg_rdata_o =
    (dbg_raddr_i == 5'd0) ? 32'd0 : rf_q[dbg_raddr_i];
`endif

  always_comb begin
    imm_ext = 32'd0;
    case (imm_src_i)
      3'b000: imm_ext = {{20{ir_q[31]}}, ir_q[31:20]};
      3'b001: imm_ext = {{20{ir_q[31]}}, ir_q[31:25],
                         ir_q[11:7]};
      3'b010: imm_ext = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                         ir_q[30:25], ir_q[11:8], 1'b0};
      3'b011: imm_ext = {{11{ir_q[31]}}, ir_q[31],
                         ir_q[19:12], ir_q[20],
                         ir_q[30:21], 1'b0};
      3'b100: imm_ext = {ir_q[31:12], 12'd0};
      default: imm_ext = 32'd0;
    endcase
  end

  always_comb begin
    src_a = 32'd0;
    case (alu_src_a_i)
      2'b00: src_a = pc_q;
      2'b01: src_a = old_pc_q;
      2'b10: src_a = a_q;
      default: src_a = 32'd0;
    endcase
  end

  always_comb begin
    src_b = 32'd0;
    case (alu_src_b_i)
      2'b00: src_b = b_q;
      2'b01: src_b = imm_ext;
      2'b10: src_b = 32'd4;
      default: src_b = 32'd0;
    endcase
  end

  always_comb begin
    alu_result = 32'd0;
    case (alu_control_i)
      3'b000: alu_result = src_a + src_b;
      3'b001: alu_result = src_a - src_b;
      3'b010: alu_result = src_a & src_b;
      3'b011: alu_result = src_a | src_b;
      3'b100: alu_result = src_a ^ src_b;
      3'b101: alu_result =
        ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
  end

  always_comb begin
    result = 32'd0;
    case (result_src_i)
      2'b00: result = alu_out_q;
      2'b01: result = data_q;
      2'b10: result = alu_result;
      default: result = imm_ext;
    endcase
  end

  assign zero_o      = (alu_result == 32'd0);
  assign op_o        = ir_q[6:0];
  assign funct3_o    = ir_q[14:12];
  assign funct7_o    = ir_q[30];
  assign mem_addr_o  = addr_src_i ? result : pc_q;
  assign mem_wdata_o = b_q;
  assign mem_we_o    = mem_write_i;

  // OldPC captures the pre-edge PC, so a combined fetch that also
  // advances PC still records the address of the fetched instruction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q      <= 32'd0;
      old_pc_q  <= 32'd0;
      ir_q      <= 32'd0;
      data_q    <= 32'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      alu_out_q <= 32'd0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= 32'd0;
      end
    end else begin
      data_q    <= mem_rdata_i;
      a_q       <= rd1;
      b_q       <= rd2;
      alu_out_q <= alu_result;
      if (ir_write_i) begin
        ir_q     <= mem_rdata_i;
        old_pc_q <= pc_q;
      end
      if (pc_write_i) begin
        pc_q <= result;
      end
      if (reg_write_i && (rd != 5'd0)) begin
        rf_q[rd] <= result;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed self-checking bench for multicycle_datapath.
// Register state is observed only through the memory/status ports.
module tb_multicycle_datapath;

  logic        clk_i;
  logic        rst_i;
  logic        pc_write_i;
  logic        addr_src_i;
  logic        mem_write_i;
  logic        ir_write_i;
  logic [1:0]  result_src_i;
  logic [2:0]  alu_control_i;
  logic [1:0]  alu_src_a_i;
  logic [1:0]  alu_src_b_i;
  logic [2:0]  imm_src_i;
  logic        reg_write_i;
  logic [6:0]  op_o;
  logic [2:0]  funct3_o;
  logic        funct7_o;
  logic        zero_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_we_o;
  logic [31:0] mem_rdata_i;

  int checks;
  int fails;

  multicycle_datapath dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pc_write_i    (pc_write_i),
    .addr_src_i    (addr_src_i),
    .mem_write_i   (mem_write_i),
    .ir_write_i    (ir_write_i),
    .result_src_i  (result_src_i),
    .alu_control_i (alu_control_i),
    .alu_src_a_i   (alu_src_a_i),
    .alu_src_b_i   (alu_src_b_i),
    .imm_src_i     (imm_src_i),
    .reg_write_i   (reg_write_i),
    .op_o          (op_o),
    .funct3_o      (funct3_o),
    .funct7_o      (funct7_o),
    .zero_o        (zero_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_we_o      (mem_we_o),
    .mem_rdata_i   (mem_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_ctrl();
    pc_write_i    = 1'b0;
    addr_src_i    = 1'b0;
    mem_write_i   = 1'b0;
    ir_write_i    = 1'b0;
    result_src_i  = 2'b00;
    alu_control_i = 3'b000;
    alu_src_a_i   = 2'b00;
    alu_src_b_i   = 2'b00;
    imm_src_i     = 3'b000;
    reg_write_i   = 1'b0;
  endtask

  task automatic load_ir(input logic [31:0] instr);
    clear_ctrl();
    mem_rdata_i = instr;
    ir_write_i  = 1'b1;
    tick();
    clear_ctrl();
  endtask

  // Route A (or OldPC) straight to mem_addr_o through the ALU.
  task automatic view_a();
    clear_ctrl();
    alu_src_a_i  = 2'b10;
    alu_src_b_i  = 2'b11;
    result_src_i = 2'b10;
    addr_src_i   = 1'b1;
    #1;
  endtask

  task automatic view_old_pc();
    clear_ctrl();
    alu_src_a_i  = 2'b01;
    alu_src_b_i  = 2'b11;
    result_src_i = 2'b10;
    addr_src_i   = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_ctrl();
    mem_rdata_i = 32'd0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    checks++;
    if (op_o !== 7'd0) begin
      fails++;
      $display("FAIL reset_op got %h want 00", op_o);
    end
    checks++;
    if (funct3_o !== 3'd0 || funct7_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_funct got %h/%b want 0/0",
               funct3_o, funct7_o);
    end
    checks++;
    if (mem_addr_o !== 32'd0) begin
      fails++;
      $display("FAIL reset_pc got %h want 0", mem_addr_o);
    end
    checks++;
    if (mem_wdata_o !== 32'd0) begin
      fails++;
      $display("FAIL reset_wdata got %h want 0", mem_wdata_o);
    end
    checks++;
    if (zero_o !== 1'b1 || mem_we_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_zero_we got %b/%b want 1/0",
               zero_o, mem_we_o);
    end
  endtask

  task automatic test_fetch();
    clear_ctrl();
    mem_rdata_i   = 32'h0050_0093;
    ir_write_i    = 1'b1;
    alu_src_b_i   = 2'b10;
    result_src_i  = 2'b10;
    pc_write_i    = 1'b1;
    tick();
    clear_ctrl();
    #1;
    checks++;
    if (op_o !== 7'h13 || funct3_o !== 3'd0 || funct7_o !== 1'b0) begin
      fails++;
      $display("FAIL fetch_ir got %h/%h/%b want 13/0/0",
               op_o, funct3_o, funct7_o);
    end
    checks++;
    if (mem_addr_o !== 32'd4) begin
      fails++;
      $display("FAIL fetch_pc got %h want 4", mem_addr_o);
    end
    view_old_pc();
    checks++;
    if (mem_addr_o !== 32'd0) begin
      fails++;
      $display("FAIL fetch_oldpc got %h want 0", mem_addr_o);
    end
  endtask

  task automatic test_addi_writeback();
    clear_ctrl();
    alu_src_a_i = 2'b10;
    alu_src_b_i = 2'b01;
    tick();
    clear_ctrl();
    addr_src_i = 1'b1;
    #1;
    checks++;
    if (mem_addr_o !== 32'd5) begin
      fails++;
      $display("FAIL addi_aluout got %h want 5", mem_addr_o);
    end
    reg_write_i = 1'b1;
    tick();
    load_ir(32'h0000_8013);
    tick();
    view_a();
    checks++;
    if (mem_addr_o !== 32'd5) begin
      fails++;
      $display("FAIL addi_x1 got %h want 5", mem_addr_o);
    end
    view_old_pc();
    checks++;
    if (mem_addr_o !== 32'd4) begin
      fails++;
      $display("FAIL oldpc_no_pcw got %h want 4", mem_addr_o);
    end
  endtask

  task automatic test_read_during_write();
    load_ir(32'h0010_8093);
    tick();
    alu_src_a_i  = 2'b10;
    alu_src_b_i  = 2'b01;
    result_src_i = 2'b10;
    reg_write_i  = 1'b1;
    tick();
    view_a();
    checks++;
    if (mem_addr_o !== 32'd5) begin
      fails++;
      $display("FAIL rdw_old got %h want 5", mem_addr_o);
    end
    tick();
    #1;
    checks++;
    if (mem_addr_o !== 32'd6) begin
      fails++;
      $display("FAIL rdw_new got %h want 6", mem_addr_o);
    end
  endtask

  task automatic test_x0_guard();
    load_ir(32'h0000_0013);
    mem_rdata_i = 32'hDEAD_BEEF;
    tick();
    result_src_i = 2'b01;
    addr_src_i   = 1'b1;
    #1;
    checks++;
    if (mem_addr_o !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL x0_result got %h want deadbeef", mem_addr_o);
    end
    reg_write_i = 1'b1;
    tick();
    clear_ctrl();
    mem_rdata_i = 32'd0;
    tick();
    view_a();
    checks++;
    if (mem_addr_o !== 32'd0 || mem_wdata_o !== 32'd0) begin
      fails++;
      $display("FAIL x0_read got %h/%h want 0/0",
               mem_addr_o, mem_wdata_o);
    end
    clear_ctrl();
    alu_src_a_i = 2'b10;
    #1;
    checks++;
    if (zero_o !== 1'b1) begin
      fails++;
      $display("FAIL x0_zero got %b want 1", zero_o);
    end
  endtask

  task automatic test_imm();
    logic [31:0] exp_imm [6];
    exp_imm = '{32'hFFFF_FFED, 32'hFFFF_FFF5, 32'hFFFF_FFF4,
                32'hFFFC_BFEC, 32'hFEDC_B000, 32'h0000_0000};
    load_ir(32'hFEDC_BA97);
    checks++;
    if (op_o !== 7'h17 || funct3_o !== 3'd3 || funct7_o !== 1'b1) begin
      fails++;
      $display("FAIL imm_status got %h/%h/%b want 17/3/1",
               op_o, funct3_o, funct7_o);
    end
    for (int k = 0; k < 6; k++) begin
      clear_ctrl();
      result_src_i = 2'b11;
      addr_src_i   = 1'b1;
      imm_src_i    = 3'(k);
      #1;
      checks++;
      if (mem_addr_o !== exp_imm[k]) begin
        fails++;
        $display("FAIL imm_src%0d got %h want %h",
                 k, mem_addr_o, exp_imm[k]);
      end
    end
  endtask

  task automatic test_branch_alu();
    logic [31:0] exp_alu [6];
    exp_alu = '{32'h0, 32'hF, 32'hF, 32'h1, 32'h0, 32'h0};
    load_ir(32'h0070_0113);
    alu_src_a_i  = 2'b11;
    alu_src_b_i  = 2'b01;
    result_src_i = 2'b10;
    reg_write_i  = 1'b1;
    tick();
    load_ir(32'h0080_0193);
    alu_src_a_i  = 2'b11;
    alu_src_b_i  = 2'b01;
    result_src_i = 2'b10;
    reg_write_i  = 1'b1;
    tick();
    load_ir(32'h0021_0063);
    tick();
    alu_src_a_i   = 2'b10;
    alu_control_i = 3'b001;
    #1;
    checks++;
    if (zero_o !== 1'b1 || op_o !== 7'h63) begin
      fails++;
      $display("FAIL beq_eq got zero=%b op=%h want 1/63",
               zero_o, op_o);
    end
    load_ir(32'h0031_0063);
    tick();
    alu_src_a_i   = 2'b10;
    alu_control_i = 3'b001;
    result_src_i  = 2'b10;
    addr_src_i    = 1'b1;
    #1;
    checks++;
    if (zero_o !== 1'b0 || mem_addr_o !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL beq_ne got zero=%b res=%h want 0/ffffffff",
               zero_o, mem_addr_o);
    end
    for (int k = 0; k < 6; k++) begin
      alu_control_i = 3'(k + 2);
      #1;
      checks++;
      if (mem_addr_o !== exp_alu[k]) begin
        fails++;
        $display("FAIL alu_op%0d got %h want %h",
                 k + 2, mem_addr_o, exp_alu[k]);
      end
    end
    load_ir(32'hFFF1_0093);
    tick();
    alu_src_a_i   = 2'b10;
    alu_src_b_i   = 2'b01;
    alu_control_i = 3'b101;
    result_src_i  = 2'b10;
    addr_src_i    = 1'b1;
    #1;
    checks++;
    if (mem_addr_o !== 32'd0) begin
      fails++;
      $display("FAIL slt_signed got %h want 0", mem_addr_o);
    end
  endtask

  task automatic test_store();
    load_ir(32'h0000_0213);
    mem_rdata_i = 32'h0000_CAFE;
    tick();
    result_src_i = 2'b01;
    reg_write_i  = 1'b1;
    tick();
    load_ir(32'h1040_2023);
    mem_rdata_i = 32'd0;
    tick();
    addr_src_i   = 1'b1;
    result_src_i = 2'b10;
    imm_src_i    = 3'b001;
    alu_src_a_i  = 2'b11;
    alu_src_b_i  = 2'b01;
    mem_write_i  = 1'b1;
    #1;
    checks++;
    if (mem_addr_o !== 32'h100) begin
      fails++;
      $display("FAIL store_addr got %h want 100", mem_addr_o);
    end
    checks++;
    if (mem_wdata_o !== 32'hCAFE) begin
      fails++;
      $display("FAIL store_wdata got %h want cafe", mem_wdata_o);
    end
    checks++;
    if (mem_we_o !== 1'b1) begin
      fails++;
      $display("FAIL store_we got %b want 1", mem_we_o);
    end
  endtask

  task automatic test_reset_abort();
    load_ir(32'h0010_8093);
    alu_src_a_i  = 2'b11;
    alu_src_b_i  = 2'b10;
    result_src_i = 2'b10;
    reg_write_i  = 1'b1;
    pc_write_i   = 1'b1;
    rst_i        = 1'b1;
    tick();
    rst_i = 1'b0;
    clear_ctrl();
    #1;
    checks++;
    if (mem_addr_o !== 32'd0 || op_o !== 7'd0) begin
      fails++;
      $display("FAIL abort_pc got %h op=%h want 0/00",
               mem_addr_o, op_o);
    end
    load_ir(32'h0000_8013);
    tick();
    view_a();
    checks++;
    if (mem_addr_o !== 32'd0) begin
      fails++;
      $display("FAIL abort_x1 got %h want 0", mem_addr_o);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst_i  = 1'b1;
    mem_rdata_i = 32'd0;
    clear_ctrl();
    test_reset();
    test_fetch();
    test_addi_writeback();
    test_read_during_write();
    test_x0_guard();
    test_imm();
    test_branch_alu();
    test_store();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
